// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl -- debug sequencer between board buttons and the multicycle
// RISC-V core. Turns debounced button levels into a clock-enable stream that
// gates every state register in the core, and counts cycles/instructions.
//
// Advance modes: cycle step (one CU state per press), instruction step (run
// until the CU returns to Fetch, bounded by STEP_TIMEOUT) and free run
// (until the run button is pressed again or a PC breakpoint is hit).
//
// Optional feature macro: STEP_CTRL_BP_EN -- when defined, the PC breakpoint
// logic is present; when undefined, bp_match/bp_hit are tied low and
// pc/bp_addr/bp_en are ignored.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   btn_step        debounced step button level
//   btn_run         debounced run/halt toggle button level
//   mode_instr      1 = instruction step, 0 = cycle step (used on step press)
//   cu_state        current CU state from the core
//   pc              current PC from the core
//   bp_addr, bp_en  breakpoint address / enable
//   cnt_clr         synchronous clear of both counters
//   cpu_ce          core clock enable (Mealy)
//   halted          controller is in HALT
//   bp_hit          sticky: run stopped on the breakpoint
//   timeout         sticky: instruction step hit STEP_TIMEOUT
//   cycle_cnt       enabled cycles
//   instr_cnt       Fetch states executed
module cpu_step_ctrl #(
  parameter logic [3:0] FETCH_STATE  = 4'b0001,
  parameter int         STEP_TIMEOUT = 16,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             mode_instr,
  input  logic [3:0]       cu_state,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_en,
  input  logic             cnt_clr,
  output logic             cpu_ce,
  output logic             halted,
  output logic             bp_hit,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {HALT, STEP_CYC, STEP_INS, RUN} state_t;

  localparam logic [7:0] STEP_LAST = 8'(STEP_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       step_q, run_q;
  logic       rise_step, rise_run;
  logic       first;
  logic [7:0] step_cnt;
  logic       is_fetch, bp_match;
  logic       ins_stop, run_stop;
  logic       enter, set_bp, set_to;

  assign rise_step = btn_step & ~step_q;
  assign rise_run  = btn_run  & ~run_q;
  assign is_fetch  = (cu_state == FETCH_STATE);

`ifdef STEP_CTRL_BP_EN
  assign bp_match = bp_en & is_fetch & (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_en};
  assign bp_match  = 1'b0;
`endif

  // 'first' masks the stop condition on the first enabled cycle so a step
  // or run started at Fetch (or parked on the breakpoint) still makes progress.
  assign ins_stop = is_fetch & ~first;
  assign run_stop = bp_match & ~first;

  always_comb begin
    state_nxt = state;
    cpu_ce    = 1'b0;
    enter     = 1'b0;
    set_bp    = 1'b0;
    set_to    = 1'b0;
    case (state)
      HALT: begin
        if (rise_run) begin
          state_nxt = RUN;
          enter     = 1'b1;
        end else if (rise_step) begin
          if (mode_instr) begin
            state_nxt = STEP_INS;
            enter     = 1'b1;
          end else begin
            state_nxt = STEP_CYC;
          end
        end
      end
      STEP_CYC: begin
        cpu_ce    = 1'b1;
        state_nxt = HALT;
      end
      STEP_INS: begin
        cpu_ce = ~ins_stop;
        if (ins_stop) begin
          state_nxt = HALT;
        end else if (step_cnt == STEP_LAST) begin
          // this enabled cycle is the last one allowed
          state_nxt = HALT;
          set_to    = 1'b1;
        end
      end
      RUN: begin
        cpu_ce = ~run_stop;
        if (run_stop) begin
          state_nxt = HALT;
          set_bp    = 1'b1;
        end else if (rise_run) begin
          state_nxt = HALT;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HALT;
      step_q   <= 1'b1;  // held-through-reset buttons produce no edge
      run_q    <= 1'b1;
      first    <= 1'b0;
      step_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= btn_step;
      run_q  <= btn_run;
      if (enter) begin
        first    <= 1'b1;
        step_cnt <= '0;
        timeout  <= 1'b0;
      end else begin
        if (cpu_ce) first <= 1'b0;
        if (cpu_ce && state == STEP_INS) step_cnt <= step_cnt + 8'd1;
        if (set_to) timeout <= 1'b1;
      end
    end
  end

`ifdef STEP_CTRL_BP_EN
  always_ff @(posedge clk) begin
    if (rst)         bp_hit <= 1'b0;
    else if (enter)  bp_hit <= 1'b0;
    else if (set_bp) bp_hit <= 1'b1;
  end
`else
  logic unused_set_bp;
  assign unused_set_bp = set_bp;
  assign bp_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cpu_ce) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (is_fetch) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Debug sequencer between the board buttons and the multicycle RISC-V core. It turns debounced button levels into a single-cycle clock-enable stream (`cpu_ce`) that gates every state register in the core (PC, IR, register file, CU state). It supports three ways of advancing the core:
- cycle step: one CU state per press;
- instruction step: run until the CU next returns to Fetch;
- free run: run until halted by button or PC breakpoint.

It also keeps cycle and instruction counters for the display.

## Interface
Parameters:
- `FETCH_STATE`, 4'b0001: CU encoding of S1_Fetch; marks the instruction boundary.
- `STEP_TIMEOUT`, 16: maximum enabled cycles per instruction step before forced halt; range 2–255.
- `CNT_W`, 32: width of `cycle_cnt` and `instr_cnt`.

Ports:
- `clk`, in, 1: single clock. The whole block and the core use this clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `btn_step`, in, 1: debounced step button level.
- `btn_run`, in, 1: debounced run/halt toggle button level.
- `mode_instr`, in, 1: step granularity. 1 = instruction step, 0 = cycle step. Sampled on the `btn_step` rising edge.
- `cu_state`, in, 4: current CU state from the core.
- `pc`, in, 32: current PC from the core.
- `bp_addr`, in, 32: breakpoint address.
- `bp_en`, in, 1: breakpoint enable.
- `cnt_clr`, in, 1: synchronous clear of both counters.
- `cpu_ce`, out, 1: core clock enable. While it is 1, the core advances at the end of the current cycle.
- `halted`, out, 1: controller is in HALT.
- `bp_hit`, out, 1: sticky flag; run stopped on the breakpoint.
- `timeout`, out, 1: sticky flag; instruction step hit `STEP_TIMEOUT`.
- `cycle_cnt`, out, CNT_W: number of enabled cycles.
- `instr_cnt`, out, CNT_W: number of Fetch states executed.

## Operation
- Button edges:
  - Each button is registered once (`btn_q`); rise = `btn & ~btn_q`.
  - `btn_q` resets to 1, so a button held through reset produces no edge.
- FSM states: HALT, STEP_CYC, STEP_INS, RUN. Reset state is HALT.
- HALT:
  - rise_run → RUN.
  - else rise_step with `mode_instr`=1 → STEP_INS.
  - else rise_step with `mode_instr`=0 → STEP_CYC.
  - rise_run and rise_step in the same cycle → RUN (run wins).
  - Entering RUN or STEP_INS clears `bp_hit` and `timeout`, sets `first`=1 and zeroes the step counter.
- STEP_CYC: `cpu_ce`=1 for exactly one cycle, then → HALT.
- STEP_INS:
  - `cpu_ce = ~stop`, where `stop = (cu_state==FETCH_STATE) & ~first`.
  - `stop` → HALT with `cpu_ce`=0 that cycle, so the core rests at Fetch.
  - Step counter increments on each enabled cycle. Reaching `STEP_TIMEOUT` → HALT and set `timeout`.
  - Button edges are ignored in this state.
- RUN:
  - `cpu_ce = ~stop`, where `stop = bp_match & ~first`.
  - `bp_match = bp_en & cu_state==FETCH_STATE & pc==bp_addr`.
  - `stop` → HALT and set `bp_hit`.
  - rise_run → HALT, with `cpu_ce`=0 from the next cycle.
  - rise_step is ignored.
- `first`: set on entry to RUN/STEP_INS, cleared after the first enabled cycle. This guarantees progress when starting from Fetch or from a breakpoint.
- Counters:
  - `cycle_cnt` += 1 on every cycle with `cpu_ce`=1.
  - `instr_cnt` += 1 when `cpu_ce`=1 and `cu_state`==FETCH_STATE.
  - Both wrap modulo 2^CNT_W.
  - `cnt_clr` wins over increment.
- `halted` = (state==HALT).

## Timing
- Reset values: `cpu_ce`=0, `halted`=1, `bp_hit`=0, `timeout`=0, `cycle_cnt`=0, `instr_cnt`=0, state=HALT.
- `cpu_ce` is a Mealy output (state plus combinational `stop`) and is glitch-free within a cycle. `stop` depends only on registered core outputs.
- Button latency: rise observed in cycle N → first `cpu_ce`=1 in cycle N+1.
- Cycle step: exactly 1 enabled cycle per press.
- Instruction step: an instruction of k CU states yields k enabled cycles, then `halted`=1 in the following cycle.
- `rst` asserted mid-step or mid-run: `cpu_ce`=0 in the next cycle, all outputs return to reset values. The core is reset by the same `rst`.

## Configuration
- `STEP_CTRL_BP_EN` defined: breakpoint logic present as described above.
- `STEP_CTRL_BP_EN` not defined:
  - `bp_match` is tied to 0 and `bp_hit` is tied to 0.
  - `bp_addr`, `bp_en` and `pc` are unused.
  - RUN ends only on rise_run or `rst`.

## Test plan
- Reset, then one `btn_step` press with `mode_instr`=0 → `cpu_ce` high 1 cycle; CU moves 0001→0010; `cycle_cnt`=1, `instr_cnt`=1; `halted`=1 afterwards.
- From Fetch, `mode_instr`=1, one press on an ADDI (CU 0001→0010→0101→0100) → 4 enabled cycles; halts with `cu_state`=0001; PC advances +4; `instr_cnt`=1.
- `bp_en`=1, `bp_addr`=0x0000000C, run from PC 0 over straight-line code → halt at Fetch with `pc`=0x0C and `bp_hit`=1. A second run press resumes past 0x0C and clears `bp_hit`.
- CU held stuck outside Fetch (stubbed `cu_state`=4'b0011) during an instruction step → exactly 16 enabled cycles, then `timeout`=1 and `halted`=1.
- `btn_run` and `btn_step` rising in the same cycle → RUN entered; no STEP behaviour. Holding a button high across `rst` → no action after release of `rst`.
- `rst` pulsed while running with `cycle_cnt`≥5 → next cycle `cpu_ce`=0, `halted`=1, both counters 0.
